// File: rtl/prog_loader_if.sv
// ---------------------------------------------------------------------------
// prog_loader_if
// Byte stream carrying a program image into prog_loader.
//   in_valid : producer has a byte on in_data
//   in_data  : stream byte (word count, then big-endian instruction words)
//   in_ready : loader accepts the byte on this rising edge
// A byte moves on a rising edge where in_valid && in_ready.
// master = byte producer, slave = loader.
// ---------------------------------------------------------------------------
interface prog_loader_if;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
// Program-load and run sequencer for the single-cycle processor. Takes a
// byte stream (count byte, then big-endian 32-bit words), writes one word
// per WRITE cycle into instruction memory, idles the load port for one GAP
// cycle, holds working high for RUN_CYCLES cycles, then reports done.
//
// Ports:
//   clock, rst_n    : rising-edge clock, asynchronous active-low reset
//   start           : one-cycle pulse, honoured in IDLE or DONE
//   abort           : level, returns to IDLE from any state (beats start)
//   stream          : byte stream slave (in_valid/in_data/in_ready)
//   addr/wr/wdata   : instruction memory load port (word index address)
//   working         : processor run enable
//   done, err       : run finished / header error; held until start/abort
// All outputs are registered.
// ---------------------------------------------------------------------------
module prog_loader #(
  parameter int IMEM_DEPTH = 32,
  parameter int RUN_CYCLES = 155
) (
  input  logic         clock,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  prog_loader_if.slave stream,
  output logic [31:0]  addr,
  output logic         wr,
  output logic [31:0]  wdata,
  output logic         working,
  output logic         done,
  output logic         err
);

  // Word index width; the count byte limits usable depth to 255 anyway.
  localparam int IDX_W = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HEADER, S_LOAD, S_WRITE, S_GAP, S_RUN, S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [7:0]       count;
  logic [IDX_W-1:0] idx;
  logic [1:0]       byte_cnt;
  logic [23:0]      shift;     // first three bytes of the word in flight
  logic [15:0]      run_cnt;
  logic             in_ready_q;

  logic             fire, hdr_ok, last_word, run_last;
  logic             in_ready_nx, wr_nx, working_nx, done_nx, err_nx;
  logic [31:0]      addr_nx, wdata_nx;

  assign stream.in_ready = in_ready_q;
  assign fire      = stream.in_valid && in_ready_q;
  assign hdr_ok    = (stream.in_data != 8'd0) &&
                     ({24'd0, stream.in_data} <= 32'(IMEM_DEPTH));
  assign last_word = (({{(9-IDX_W){1'b0}}, idx} + 9'd1) == {1'b0, count});
  assign run_last  = (run_cnt == 16'(RUN_CYCLES - 1));

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   if (start) state_nx = S_HEADER;
      S_HEADER: if (fire)  state_nx = hdr_ok ? S_LOAD : S_DONE;
      S_LOAD:   if (fire && byte_cnt == 2'd3) state_nx = S_WRITE;
      S_WRITE:  state_nx = last_word ? S_GAP : S_LOAD;
      S_GAP:    state_nx = S_RUN;
      S_RUN:    if (run_last) state_nx = S_DONE;
      S_DONE:   if (start) state_nx = S_HEADER;
      default:  state_nx = S_IDLE;
    endcase
    if (abort) state_nx = S_IDLE;
  end

  // Output decode, from the state being entered so the registered outputs
  // line up with that state.
  always_comb begin
    in_ready_nx = (state_nx == S_HEADER) || (state_nx == S_LOAD);
    wr_nx       = (state_nx == S_WRITE);
    addr_nx     = '0;
    wdata_nx    = '0;
    if (state_nx == S_WRITE) begin
      addr_nx  = 32'(idx);
      wdata_nx = {shift, stream.in_data};  // 4th byte goes straight to LSB
    end
    working_nx  = (state_nx == S_RUN);
    done_nx     = (state_nx == S_DONE);
    // Only a bad header reaches DONE from HEADER; DONE keeps its flag.
    err_nx      = (state_nx == S_DONE) &&
                  ((state == S_HEADER) || ((state == S_DONE) && err));
  end

  // Output registers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      in_ready_q <= 1'b0;
      wr         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      working    <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      in_ready_q <= in_ready_nx;
      wr         <= wr_nx;
      addr       <= addr_nx;
      wdata      <= wdata_nx;
      working    <= working_nx;
      done       <= done_nx;
      err        <= err_nx;
    end
  end

  // Datapath: count, word index, byte assembly, run counter.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      count    <= '0;
      idx      <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      run_cnt  <= '0;
    end else if (abort) begin
      // Discard any partial word so a later load starts clean.
      idx      <= '0;
      byte_cnt <= '0;
      shift    <= '0;
      run_cnt  <= '0;
    end else begin
      case (state)
        S_HEADER: if (fire && hdr_ok) begin
          count    <= stream.in_data;
          idx      <= '0;
          byte_cnt <= '0;
          shift    <= '0;
        end
        S_LOAD: if (fire) begin
          shift    <= {shift[15:0], stream.in_data};
          byte_cnt <= byte_cnt + 2'd1;   // wraps to 0 on the 4th byte
        end
        S_WRITE: if (!last_word) idx <= idx + IDX_W'(1);
        S_GAP:   run_cnt <= '0;
        S_RUN:   run_cnt <= run_cnt + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
// Scoreboard bench for prog_loader. Stimulus pushes expected memory writes,
// run windows and done/err results into queues; a negedge monitor pops and
// compares whenever the DUT writes, ends a run, or raises done.
// ---------------------------------------------------------------------------
module tb_prog_loader;

  localparam int IMEM_DEPTH = 32;
  localparam int RUN_CYCLES = 155;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    int len;
    bit done_v;
  } run_t;

  logic        clock;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [31:0] addr;
  logic        wr;
  logic [31:0] wdata;
  logic        working;
  logic        done;
  logic        err;

  prog_loader_if sif ();

  prog_loader #(.IMEM_DEPTH(IMEM_DEPTH), .RUN_CYCLES(RUN_CYCLES)) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .stream  (sif),
    .addr    (addr),
    .wr      (wr),
    .wdata   (wdata),
    .working (working),
    .done    (done),
    .err     (err)
  );

  int  checks = 0;
  int  errors = 0;
  wr_t  exp_wr[$];
  run_t exp_run[$];
  bit   exp_done[$];
  logic [31:0] prog [IMEM_DEPTH];

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard.
  initial begin
    bit   prev_working = 1'b0;
    bit   prev_done    = 1'b0;
    int   run_len      = 0;
    wr_t  ew;
    run_t er;
    bit   ed;
    forever begin
      @(negedge clock);
      if (!rst_n) begin
        prev_working = 1'b0;
        prev_done    = 1'b0;
        run_len      = 0;
      end else begin
        if (wr) begin
          if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL wr_unexpected: write addr=%0d data=0x%08h, none expected", addr, wdata);
          end else begin
            ew = exp_wr.pop_front();
            check("wr_addr", addr, ew.addr);
            check("wr_data", wdata, ew.data);
            check("wr_in_ready", {31'd0, sif.in_ready}, 32'd0);
          end
        end
        if (working) run_len++;
        else if (prev_working) begin
          if (exp_run.size() == 0) begin
            checks++; errors++;
            $display("FAIL run_unexpected: run of %0d cycles, none expected", run_len);
          end else begin
            er = exp_run.pop_front();
            check("run_len", run_len, er.len);
            check("done_at_run_end", {31'd0, done}, {31'd0, er.done_v});
          end
          run_len = 0;
        end
        if (done && !prev_done) begin
          if (exp_done.size() == 0) begin
            checks++; errors++;
            $display("FAIL done_unexpected: done rose, err=%0b", err);
          end else begin
            ed = exp_done.pop_front();
            check("done_err", {31'd0, err}, {31'd0, ed});
          end
        end
        prev_working = working;
        prev_done    = done;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic pulse_start();
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    repeat (gap) @(negedge clock);
    @(negedge clock);
    sif.in_valid = 1'b1;
    sif.in_data  = b;
    while (!sif.in_ready && waited < 50) begin
      @(negedge clock);
      waited++;
    end
    if (!sif.in_ready) begin
      checks++; errors++;
      $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, expected 1", waited);
      sif.in_valid = 1'b0;
    end else begin
      @(posedge clock);
      #1 sif.in_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget);
    int cnt = 0;
    while (!done && cnt < budget) begin
      @(negedge clock);
      cnt++;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_working(input int budget);
    int cnt = 0;
    while (!working && cnt < budget) begin
      @(negedge clock);
      cnt++;
    end
    check("working_reached", {31'd0, working}, 32'd1);
  endtask

  // Full load + run of prog[0..n-1]. Optional start pulses after a given
  // stream byte index and inside the run window must be ignored.
  task automatic load_program(input int n, input int max_gap,
                              input int start_at_byte, input bit start_in_run);
    logic [7:0] nb;
    for (int i = 0; i < n; i++) exp_wr.push_back('{32'(i), prog[i]});
    exp_run.push_back('{RUN_CYCLES, 1'b1});
    exp_done.push_back(1'b0);
    pulse_start();
    nb = 8'(n);
    send_byte(nb, 0);
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        send_byte(prog[w][31-8*b -: 8], int'($urandom_range(0, max_gap)));
        if (w*4 + b == start_at_byte) pulse_start();
      end
    end
    @(negedge clock);
    check("last_write_wr", {31'd0, wr}, 32'd1);
    @(negedge clock);
    check("gap_wr", {31'd0, wr}, 32'd0);
    check("gap_addr", addr, 32'd0);
    check("gap_wdata", wdata, 32'd0);
    check("gap_working", {31'd0, working}, 32'd0);
    @(negedge clock);
    check("run_working", {31'd0, working}, 32'd1);
    if (start_in_run) begin
      repeat (20) @(negedge clock);
      pulse_start();
    end
    wait_done(RUN_CYCLES + 20);
    check("err_after_run", {31'd0, err}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_in_ready"}, {31'd0, sif.in_ready}, 32'd0);
    check({tag, "_addr"}, addr, 32'd0);
    check({tag, "_wr"}, {31'd0, wr}, 32'd0);
    check({tag, "_wdata"}, wdata, 32'd0);
    check({tag, "_working"}, {31'd0, working}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_err"}, {31'd0, err}, 32'd0);
  endtask

  task automatic bad_header(input logic [7:0] n);
    exp_done.push_back(1'b1);
    pulse_start();
    check("start_clears_done", {31'd0, done}, 32'd0);
    check("start_in_ready", {31'd0, sif.in_ready}, 32'd1);
    send_byte(n, 0);
    @(negedge clock);
    check("bad_hdr_done", {31'd0, done}, 32'd1);
    check("bad_hdr_err", {31'd0, err}, 32'd1);
    check("bad_hdr_in_ready", {31'd0, sif.in_ready}, 32'd0);
    repeat (5) @(negedge clock);
    check("bad_hdr_working", {31'd0, working}, 32'd0);
  endtask

  initial begin
    rst_n        = 1'b0;
    start        = 1'b0;
    abort        = 1'b0;
    sif.in_valid = 1'b0;
    sif.in_data  = 8'h00;

    // Reset state before any clock edge.
    #3;
    check_outputs_zero("reset");
    @(negedge clock) rst_n = 1'b1;
    @(negedge clock);

    // Two-word program.
    prog[0] = 32'h10F00001;
    prog[1] = 32'h7000000A;
    load_program(2, 0, -1, 1'b0);

    // Bad headers: zero and one past depth.
    bad_header(8'h00);
    bad_header(8'h21);

    // Full-depth load with random in_valid gaps.
    for (int i = 0; i < IMEM_DEPTH; i++)
      prog[i] = {i[7:0], 8'hA0 + i[7:0], ~i[7:0], 8'h5A ^ i[7:0]};
    load_program(IMEM_DEPTH, 2, -1, 1'b0);

    // Abort in the 50th run cycle, then a clean reload.
    prog[0] = 32'h12345678;
    exp_wr.push_back('{32'd0, prog[0]});
    exp_run.push_back('{50, 1'b0});
    pulse_start();
    send_byte(8'd1, 0);
    for (int b = 0; b < 4; b++) send_byte(prog[0][31-8*b -: 8], 0);
    wait_working(10);
    repeat (49) @(negedge clock);
    abort = 1'b1;
    @(negedge clock) abort = 1'b0;
    check_outputs_zero("abort");
    prog[0] = 32'h0000FFFF;
    prog[1] = 32'hFFFF0000;
    prog[2] = 32'h80000001;
    load_program(3, 0, -1, 1'b0);

    // Abort and start in the same cycle: abort wins.
    @(negedge clock) begin abort = 1'b1; start = 1'b1; end
    @(negedge clock) begin abort = 1'b0; start = 1'b0; end
    check_outputs_zero("abort_start");

    // Async reset mid-word, then a fresh load must not merge stale bytes.
    pulse_start();
    send_byte(8'd3, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("async_rst");
    @(negedge clock) rst_n = 1'b1;
    prog[0] = 32'hDEADBEEF;
    load_program(1, 0, -1, 1'b0);

    // start pulsed during LOAD and during RUN is ignored.
    prog[0] = 32'hCAFEF00D;
    prog[1] = 32'h0BADC0DE;
    load_program(2, 1, 5, 1'b1);

    repeat (5) @(negedge clock);
    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_run_drained", exp_run.size(), 0);
    check("exp_done_drained", exp_done.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
